mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store bridge between the datapath and a req/gnt/rvalid memory bus.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses fault without any bus cycle.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        memory_done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [1:0]  SIZE_BYTE   = 2'b00;
    localparam logic [1:0]  SIZE_HALF   = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        fault;
    logic        timeout_hit;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        fault = 1'b0;
        if (size_i == SIZE_HALF) begin
            fault = addr_i[0];
        end else if (size_i[1]) begin
            fault = |addr_i[1:0];
        end
    end
`else
    assign fault = 1'b0;
`endif

    // cnt_q counts completed WAIT_RSP cycles; the next edge would make it TIMEOUT.
    assign timeout_hit = (TIMEOUT_CNT != 16'd0) && ((cnt_q + 16'd1) == TIMEOUT_CNT);

    always_comb begin
        case (addr_q[1:0])
            2'd0:    load_byte = bus_rdata_i[7:0];
            2'd1:    load_byte = bus_rdata_i[15:8];
            2'd2:    load_byte = bus_rdata_i[23:16];
            default: load_byte = bus_rdata_i[31:24];
        endcase
        load_half = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    end

    always_comb begin
        case (size_q)
            SIZE_BYTE: load_data = {{24{~unsigned_q & load_byte[7]}}, load_byte};
            SIZE_HALF: load_data = {{16{~unsigned_q & load_half[15]}}, load_half};
            default:   load_data = bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (fault) begin
                        state_d = DONE;
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = WAIT_GNT;
                        we_d       = we_i;
                        size_d     = size_i;
                        unsigned_d = unsigned_i;
                        addr_d     = addr_i;
                        wdata_d    = wdata_i;
                    end
                end
            end
            WAIT_GNT: begin
                if (bus_gnt_i) begin
                    state_d = WAIT_RSP;
                    cnt_d   = 16'd0;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + 16'd1;
                // A response arriving on the final allowed cycle still wins over the timeout.
                if (bus_rvalid_i) begin
                    state_d = DONE;
                    rdata_d = load_data;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            cnt_q      <= 16'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        case (size_q)
            SIZE_BYTE: bus_be_o = 4'b0001 << addr_q[1:0];
            SIZE_HALF: bus_be_o = 4'b0011 << {addr_q[1], 1'b0};
            default:   bus_be_o = 4'b1111;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone select the target bytes.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        assign bus_wdata_o[8*gi +: 8] = (size_q == SIZE_BYTE) ? wdata_q[7:0] :
                                        (size_q == SIZE_HALF) ? wdata_q[8*(gi%2) +: 8] :
                                                                wdata_q[8*gi +: 8];
    end

    assign bus_req_o     = (state_q == WAIT_GNT);
    assign bus_we_o      = we_q;
    assign bus_addr_o    = {addr_q[31:2], 2'b00};
    assign memory_done_o = ((state_q == IDLE) && !req_i) || (state_q == DONE);
    assign rdata_o       = rdata_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver queues expectations from a reference model,
// a bus responder plays memory, and a monitor checks every completion and the idle/hold behaviour.
module tb_mem_access_unit;

    localparam int unsigned TO = 8;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        memory_done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'd0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .we_i         (we_i),
        .size_i       (size_i),
        .unsigned_i   (unsigned_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .memory_done_o(memory_done_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          issue;
    } exp_t;

    typedef struct {
        int          g;
        int          d;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } plan_t;

    exp_t        exp_q[$];
    plan_t       plan_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          txn_no = 0;
    bit          rst_edge = 1'b0;
    bit          abort = 1'b0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    bit          hold_known = 1'b1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %08h, required %08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0b, required %0b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_fault(input logic [1:0] size, input logic [31:0] addr);
        return TRAP_EN && ((size == 2'd1 && (addr % 2) != 0) || (size >= 2'd2 && (addr % 4) != 0));
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int a;
        a = int'(addr % 4);
        if (size == 2'd0) return 4'(1 << a);
        if (size == 2'd1) return 4'(3 << ((a / 2) * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wdata);
        if (size == 2'd0) return (wdata & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (wdata & 32'hFFFF) * 32'h00010001;
        return wdata;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
        int          a;
        logic [31:0] v;
        a = int'(addr % 4);
        if (size == 2'd0) begin
            v = (rdata >> (8 * a)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = (rdata >> (16 * (a / 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int g, input int d, input logic [31:0] rd, input int gap);
        bit    f;
        bit    to;
        bit    seen;
        exp_t  e;
        plan_t p;
        if (abort) return;
        f  = m_fault(size, addr);
        to = (d >= int'(TO));
        if (!f) begin
            p = '{g, d, rd, we, addr & ~32'h3, m_be(size, addr), m_wdata(size, wdata)};
            plan_q.push_back(p);
        end
        e.we    = we;
        e.err   = f || to;
        e.rdata = e.err ? 32'd0 : m_load(size, uns, addr, rd);
        e.lat   = f ? 1 : (to ? g + 2 + int'(TO) : g + 3 + d);
        @(posedge clk);
        #1;
        req_i      = 1'b1;
        we_i       = we;
        size_i     = size;
        unsigned_i = uns;
        addr_i     = addr;
        wdata_i    = wdata;
        e.issue    = cyc;
        exp_q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            seen = memory_done_o;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL done_wait: memory_done_o stayed 0 for 64 cycles, required 1");
            abort = 1'b1;
            return;
        end
        if (gap > 0) begin
            @(posedge clk);
            #1;
            req_i = 1'b0;
            repeat (gap - 1) @(posedge clk);
        end
    endtask

    // Reset asserted while the access waits for its response; the response then lands in IDLE.
    task automatic reset_mid();
        plan_t p;
        if (abort) return;
        p = '{0, 2, $urandom, 1'b0, 32'h400, m_be(2'd2, 32'h400), m_wdata(2'd2, 32'd0)};
        plan_q.push_back(p);
        @(posedge clk);
        #1;
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; unsigned_i = 1'b0;
        addr_i = 32'h400; wdata_i = 32'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        $display("txn %0d: reset during WAIT_RSP, late rvalid ignored", txn_no);
        txn_no++;
    endtask

    always @(posedge clk) begin
        cyc      = cyc + 1;
        rst_edge = !rst_n;
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_edge) begin
            chk1("rst_bus_req", bus_req_o, 1'b0);
            chk1("rst_done", memory_done_o, !req_i);
            chk32("rst_rdata", rdata_o, 32'd0);
            chk1("rst_err", err_o, 1'b0);
            last_rdata = 32'd0;
            last_err   = 1'b0;
            hold_known = 1'b1;
        end else if (rst_n) begin
            if (req_i && memory_done_o) begin
                if (exp_q.size() == 0) begin
                    chk1("unexpected_done", 1'b1, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk1("err", err_o, mon_e.err);
                    if (!mon_e.we || mon_e.err) chk32("rdata", rdata_o, mon_e.rdata);
                    chk32("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
                    $display("txn %0d: we=%0b addr=%08h size=%0d err=%0b rdata=%08h lat=%0d",
                             txn_no, mon_e.we, addr_i, size_i, err_o, rdata_o, cyc - mon_e.issue);
                    txn_no++;
                    last_rdata = mon_e.rdata;
                    last_err   = mon_e.err;
                    hold_known = !mon_e.we || mon_e.err;
                end
            end else begin
                if (!req_i) chk1("idle_done", memory_done_o, 1'b1);
                if (hold_known) begin
                    chk32("rdata_hold", rdata_o, last_rdata);
                    chk1("err_hold", err_o, last_err);
                end
            end
        end
    end

    // ---------------- bus responder ----------------
    initial begin : responder
        plan_t p;
        forever begin
            @(negedge clk);
            if (bus_req_o) begin
                if (plan_q.size() == 0) begin
                    chk1("bus_unexpected_req", bus_req_o, 1'b0);
                    bus_gnt_i = 1'b0;
                end else begin
                    p = plan_q.pop_front();
                    chk1("bus_we", bus_we_o, p.we);
                    chk32("bus_addr", bus_addr_o, p.addr);
                    chk32("bus_be", 32'(bus_be_o), 32'(p.be));
                    if (p.we) chk32("bus_wdata", bus_wdata_o, p.wdata);
                    for (int k = 0; k <= p.g; k++) begin
                        if (k > 0) begin
                            @(negedge clk);
                            chk1("bus_req_hold", bus_req_o, 1'b1);
                        end
                        bus_gnt_i    = (k == p.g);
                        bus_rvalid_i = 1'($urandom_range(0, 1));
                        bus_rdata_i  = $urandom;
                    end
                    for (int k = 0; k < int'(TO); k++) begin
                        @(negedge clk);
                        if (k == 0) chk1("bus_req_drop", bus_req_o, 1'b0);
                        bus_gnt_i    = 1'($urandom_range(0, 1));
                        bus_rvalid_i = (k == p.d);
                        bus_rdata_i  = (k == p.d) ? p.rdata : $urandom;
                        if (k == p.d) break;
                    end
                end
            end else begin
                bus_gnt_i    = 1'($urandom_range(0, 1));
                bus_rvalid_i = 1'($urandom_range(0, 1));
                bus_rdata_i  = $urandom;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [1:0]  sz;
        logic [31:0] a;
        int          d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 0, 0, 32'hDEADBEEF, 0);
        do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 0, 1, 32'h80112233, 1);
        do_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 1, 0, 32'h80112233, 0);
        do_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 4, 0, 32'h0, 2);
        do_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 0, 99, 32'h12345678, 1);
        do_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 1, 1, 32'hCAFEF00D, 1);
        do_txn(1'b0, 2'd1, 1'b0, 32'h206, 32'd0, 2, 7, 32'h8001_7FFF, 0);
        do_txn(1'b0, 2'd3, 1'b0, 32'h20C, 32'd0, 0, 3, 32'h0BADF00D, 2);
        reset_mid();

        for (int i = 0; i < 80 && !abort; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            d  = ($urandom_range(0, 9) == 0) ? int'(TO) + 1 : int'($urandom_range(0, TO - 1));
            do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   int'($urandom_range(0, 5)), d, $urandom, int'($urandom_range(0, 2)));
        end

        @(posedge clk);
        #1;
        req_i = 1'b0;
        repeat (3) @(posedge clk);
        chk32("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk32("plan_queue_empty", 32'(plan_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
